// File: rtl/buff_uart_pkg.sv
// buff_uart_pkg
// Shared types and constants for the buffered UART.
//   rx_state_t    : receive FSM states
//   clks_per_bit  : clock cycles per serial bit (integer division)
//   START_LEVEL / STOP_LEVEL : line levels of the frame delimiters
package buff_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/buff_uart_sync.sv
// buff_uart_sync
// Multi-flop synchroniser for an asynchronous level input. All stages reset
// to 1 so an idle-high serial line reads as idle straight out of reset.
// Ports:
//   clock : sampling clock
//   reset : asynchronous active-high reset
//   d     : asynchronous input
//   q     : synchronised output (DEPTH clocks of latency)
module buff_uart_sync #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stages <= '1;
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/buff_uart_rx.sv
// buff_uart_rx
// Serial receive front end: synchronises rx, finds start bits, samples each
// data bit at its centre, checks the stop bit and presents the byte on a
// valid/ready output register.
// Ports:
//   clock         : sole clock, rising edge
//   reset         : asynchronous active-high reset
//   rx            : asynchronous serial input, idle high
//   data_out      : received byte, stable while out_valid=1
//   out_valid     : output register holds a byte
//   out_ready     : consumer accepts the byte this cycle
//   framing_error : one-cycle pulse, stop bit sampled low
//   overrun       : one-cycle pulse, good frame dropped (output still full)
//   rx_state      : current FSM state (debug visibility)
//
// Handshake: a byte transfers on a rising edge where out_valid && out_ready.
// out_valid is a pure register; out_ready only affects the next state, never
// out_valid combinationally. out_ready while out_valid=0 is ignored.
module buff_uart_rx
  import buff_uart_pkg::*;
#(
  parameter int width      = 8,
  parameter int baud_rate  = 9600,
  parameter int clock_freq = 460800
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic [width-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             framing_error,
  output logic             overrun,
  output logic [2:0]       rx_state
);

  localparam int C     = clks_per_bit(clock_freq, baud_rate);
  localparam int H     = C / 2;
  localparam int CNT_W = $clog2(C);
  localparam int IDX_W = (width > 1) ? $clog2(width) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(C - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(width - 1);

  if (C < 4) begin : g_c_too_small
    $error("buff_uart_rx: clock_freq/baud_rate must be at least 4");
  end
  if (width < 2) begin : g_width_too_small
    $error("buff_uart_rx: width must be at least 2");
  end

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [width-1:0] shift;

  buff_uart_sync #(.DEPTH(2)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      data_out      <= '0;
      out_valid     <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      // Drain; a byte loaded by the STOP branch below overrides this.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_s == START_LEVEL) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Re-check the line half a bit in; a high level means it was a glitch.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            if (rx_s == START_LEVEL) begin
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Sampling point is now mid-bit; LSB arrives first and shifts down.
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[width-1:1]};
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s == STOP_LEVEL) begin
              state <= IDLE;
              if (!out_valid || out_ready) begin
                data_out  <= shift;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A line held low must return high before another frame can start.
        BREAK: begin
          if (rx_s == STOP_LEVEL) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign rx_state = state;

endmodule

// File: tb/tb_buff_uart_rx.sv
// tb_buff_uart_rx
// Self-checking bench for buff_uart_rx at default parameters (C=48, H=24).
// A negedge monitor records handshakes and error pulses; each test task
// drives serial frames and compares against expectations derived from the
// frame format and the documented timing.
module tb_buff_uart_rx;
  import buff_uart_pkg::*;

  localparam int W = 8;
  localparam int C = 460800 / 9600;
  localparam int H = C / 2;
  // Inputs change just after a rising edge: two synchroniser edges, then
  // the FSM sees rx_s=0 (cycle T); stop sample ends cycle T+H+(W+1)*C and
  // out_valid shows in the following cycle.
  localparam int LAT = 2 + H + (W + 1) * C + 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         rx = 1'b1;
  logic         out_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         framing_error;
  logic         overrun;
  logic [2:0]   rx_state;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  buff_uart_rx #(.width(W), .baud_rate(9600), .clock_freq(460800)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .rx_state      (rx_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back(data_out);
      if (out_valid) valid_cnt++;
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  // ---------------- driver ----------------
  // Starts driving at the caller's current time (tick-aligned); leaves rx at
  // the stop level on return.
  task automatic send_frame(input logic [W-1:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < W; i++) begin
      rx = b[i];
      repeat (C) tick();
    end
    rx = stop_bit;
    repeat (C) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", framing_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", overrun); end
    reset = 1'b0;
    repeat (4) tick();
    checks++; if (rx_state !== 3'(IDLE)) begin errors++; $display("FAIL reset_state: got %0d expected %0d", rx_state, IDLE); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    int n;
    int v0, fe0, ov0;
    bit found;
    v0 = valid_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    got_q.delete();
    out_ready = 1'b1;
    n = 0; found = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (n < LAT + 100 && !found) begin
          tick();
          n++;
          if (out_valid) found = 1'b1;
        end
      end
    join
    rx = 1'b1;
    repeat (C) tick();
    checks++; if (!found || n != LAT) begin errors++; $display("FAIL basic_latency: got %0d (found=%0d) expected %0d", n, found, LAT); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", data_out); end
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cnt - v0); end
    checks++; if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin errors++; $display("FAIL basic_no_err: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", got_q.size()); end
  endtask

  task automatic test_framing();
    int v0, fe0;
    v0 = valid_cnt; fe0 = fe_cnt;
    out_ready = 1'b1;
    send_frame(8'h5A, 1'b0);
    rx = 1'b0;
    repeat (200) tick();
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL framing_pulse: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL framing_no_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (rx_state !== 3'(BREAK)) begin errors++; $display("FAIL framing_break: got %0d expected %0d", rx_state, BREAK); end
    rx = 1'b1;
    repeat (C) tick();
    got_q.delete();
    send_frame(8'h01, 1'b1);
    rx = 1'b1;
    repeat (C) tick();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL framing_recover_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h01) begin errors++; $display("FAIL framing_recover_data: got %h expected 01", got_q[0]); end
    end
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL framing_total: got %0d expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_glitch();
    int v0, fe0;
    v0 = valid_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (10) tick();
    rx = 1'b1;
    repeat (2 * C) tick();
    checks++; if (rx_state !== 3'(IDLE)) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", rx_state, IDLE); end
    checks++; if (valid_cnt - v0 != 0 || fe_cnt - fe0 != 0) begin errors++; $display("FAIL glitch_quiet: got v=%0d fe=%0d expected 0 0", valid_cnt - v0, fe_cnt - fe0); end
    got_q.delete();
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    repeat (C) tick();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'hFF) begin errors++; $display("FAIL glitch_next_data: got %h expected ff", got_q[0]); end
    end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    got_q.delete();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rx = 1'b1;
    repeat (C) tick();
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL overrun_hold: got %h expected 11", data_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", out_valid); end
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", ov_cnt - ov0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain_valid: got %b expected 0", out_valid); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h11) begin errors++; $display("FAIL overrun_drain_data: got n=%0d expected one 11", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_cnt;
    got_q.delete();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LAT - 1) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_kept: got %b expected 1", out_valid); end
        checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL b2b_new_data: got %h expected 22", data_out); end
      end
    join
    rx = 1'b1;
    repeat (C) tick();
    checks++; if (ov_cnt - ov0 != 0) begin errors++; $display("FAIL b2b_no_overrun: got %0d expected 0", ov_cnt - ov0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 8'h11 || got_q[1] !== 8'h22) begin errors++; $display("FAIL b2b_order: got %h %h expected 11 22", got_q[0], got_q[1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] b;
    int fe0, ov0;
    b = 8'h99;
    out_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    rx = 1'b1;
    repeat (C) tick();
    checks++; if (out_valid !== 1'b1 || data_out !== 8'h77) begin errors++; $display("FAIL rst_pre: got v=%b d=%h expected 1 77", out_valid, data_out); end
    // Start bit plus data bits 0..2, then halfway into bit 3.
    rx = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (C) tick();
    end
    rx = b[3];
    repeat (H) tick();
    reset = 1'b1;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", data_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (rx_state !== 3'(IDLE)) begin errors++; $display("FAIL rst_state: got %0d expected %0d", rx_state, IDLE); end
    rx = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (4) tick();
    got_q.delete();
    out_ready = 1'b1;
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    repeat (C) tick();
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin errors++; $display("FAIL rst_next: got n=%0d expected one 3c", got_q.size()); end
    checks++; if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin errors++; $display("FAIL rst_no_err: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  task automatic test_random();
    int exp_fe, fe0, ov0, gap;
    logic [W-1:0] b;
    bit good;
    exp_fe = 0; fe0 = fe_cnt; ov0 = ov_cnt;
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      b = W'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good);
      if (good) exp_q.push_back(b);
      else exp_fe++;
      rx = 1'b1;
      gap = good ? $urandom_range(0, C) : C + $urandom_range(0, C);
      repeat (gap) tick();
    end
    repeat (2 * C) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fe_cnt - fe0 != exp_fe) begin errors++; $display("FAIL rand_fe: got %0d expected %0d", fe_cnt - fe0, exp_fe); end
    checks++; if (ov_cnt - ov0 != 0) begin errors++; $display("FAIL rand_ov: got %0d expected 0", ov_cnt - ov0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_framing();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
